// File: rtl/cache_controller.sv
// Two-way set-associative cache controller: write-back, write-allocate, per-set LRU bit.
// Optional hit/miss counters are compiled in when CACHE_PERF_CNT_EN is defined.
module cache_controller #(
   parameter int ADDRESS_WIDTH   = 32,
   parameter int SETS            = 1024,
   parameter int WAYS            = 2,
   parameter int CACHE_LINE_SIZE = 32,
   parameter int TAG_WIDTH       = ADDRESS_WIDTH - ($clog2(SETS) + $clog2(CACHE_LINE_SIZE/8))
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cpu_req,
   input  logic                         cpu_wen,
   input  logic [ADDRESS_WIDTH-1:0]     cpu_addr,
   input  logic [CACHE_LINE_SIZE-1:0]   cpu_wdata,
   output logic                         cpu_ready,
   output logic                         cpu_done,
   output logic [CACHE_LINE_SIZE-1:0]   cpu_rdata,
   output logic                         arr_req,
   output logic [ADDRESS_WIDTH-1:0]     arr_address,
   output logic [CACHE_LINE_SIZE-1:0]   arr_data_in,
   output logic [WAYS-1:0]              arr_wen_data,
   output logic [WAYS-1:0]              arr_wen_tag,
   output logic [2*WAYS-1:0]            arr_valid_dirty_in,
   output logic [TAG_WIDTH-1:0]         arr_tag_in,
   input  logic [CACHE_LINE_SIZE*WAYS-1:0] arr_data_out,
   input  logic [2*WAYS-1:0]            arr_valid_dirty_out,
   input  logic [TAG_WIDTH*WAYS-1:0]    arr_tag_out,
   output logic                         mem_req,
   output logic                         mem_wen,
   output logic [ADDRESS_WIDTH-1:0]     mem_addr,
   output logic [CACHE_LINE_SIZE-1:0]   mem_wdata,
   input  logic                         mem_ack,
   input  logic [CACHE_LINE_SIZE-1:0]   mem_rdata
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0]                  hit_count,
   output logic [31:0]                  miss_count
`endif
);

   localparam int SET_BITS = $clog2(SETS);
   localparam int OFF_BITS = $clog2(CACHE_LINE_SIZE/8);

   // state     | meaning
   // IDLE      | ready for a request
   // LOOKUP    | array read in flight (wait), then hit/miss decision (eval)
   // WRITEBACK | dirty victim to memory
   // REFILL    | line fetch from memory
   // FILL      | one-cycle array write of target way (also used for write hits)
   // DONE      | cpu_done pulse
   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, FILL, DONE} state_t;

   state_t                       state_q;
   logic                         look_wait_q;
   logic [ADDRESS_WIDTH-1:0]     addr_q;
   logic                         wen_q;
   logic [CACHE_LINE_SIZE-1:0]   wdata_q;
   logic                         way_q;
   logic [SETS-1:0]              lru_q;

   logic [SET_BITS-1:0]          set_q;
   logic [TAG_WIDTH-1:0]         tag_q;
   logic [WAYS-1:0]              hit;
   logic                         hit_any, hit_way, vict_way, vict_dirty, tgt_way;
   logic                         lookup_eval, enter_fill;
   logic [1:0]                   vict_vd;
   logic [TAG_WIDTH-1:0]         tag0, tag1, vict_tag;
   logic [CACHE_LINE_SIZE-1:0]   data0, data1, hit_data, vict_data;
   logic [ADDRESS_WIDTH-1:0]     line_addr;
   logic [WAYS-1:0]              tgt_mask;

   assign set_q     = addr_q[OFF_BITS +: SET_BITS];
   assign tag_q     = addr_q[ADDRESS_WIDTH-1 -: TAG_WIDTH];
   assign line_addr = {tag_q, set_q, {OFF_BITS{1'b0}}};
   assign data0     = arr_data_out[CACHE_LINE_SIZE-1:0];
   assign data1     = arr_data_out[2*CACHE_LINE_SIZE-1:CACHE_LINE_SIZE];
   assign tag0      = arr_tag_out[TAG_WIDTH-1:0];
   assign tag1      = arr_tag_out[2*TAG_WIDTH-1:TAG_WIDTH];

   always_comb begin
      hit         = '0;
      hit[0]      = arr_valid_dirty_out[0] && (tag0 == tag_q);
      hit[1]      = arr_valid_dirty_out[2] && (tag1 == tag_q);
      hit_any     = |hit;
      hit_way     = hit[1];
      hit_data    = hit_way ? data1 : data0;
      vict_way    = !arr_valid_dirty_out[0] ? 1'b0 :
                    !arr_valid_dirty_out[2] ? 1'b1 : lru_q[set_q];
      vict_vd     = vict_way ? arr_valid_dirty_out[3:2] : arr_valid_dirty_out[1:0];
      vict_dirty  = vict_vd[1] & vict_vd[0];
      vict_tag    = vict_way ? tag1 : tag0;
      vict_data   = vict_way ? data1 : data0;
      lookup_eval = (state_q == LOOKUP) && look_wait_q;
      tgt_way     = (state_q == LOOKUP) ? (hit_any ? hit_way : vict_way) : way_q;
      tgt_mask    = tgt_way ? 2'b10 : 2'b01;
      enter_fill  = (lookup_eval && wen_q && (hit_any || !vict_dirty)) ||
                    ((state_q == WRITEBACK) && mem_ack && wen_q) ||
                    ((state_q == REFILL) && mem_req && mem_ack);
   end

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= IDLE;
         look_wait_q        <= 1'b0;
         addr_q             <= '0;
         wen_q              <= 1'b0;
         wdata_q            <= '0;
         way_q              <= 1'b0;
         lru_q              <= '0;
         cpu_ready          <= 1'b1;
         cpu_done           <= 1'b0;
         cpu_rdata          <= '0;
         arr_req            <= 1'b0;
         arr_address        <= '0;
         arr_data_in        <= '0;
         arr_wen_data       <= '0;
         arr_wen_tag        <= '0;
         arr_valid_dirty_in <= '0;
         arr_tag_in         <= '0;
         mem_req            <= 1'b0;
         mem_wen            <= 1'b0;
         mem_addr           <= '0;
         mem_wdata          <= '0;
`ifdef CACHE_PERF_CNT_EN
         hit_cnt_q          <= '0;
         miss_cnt_q         <= '0;
`endif
      end else begin
         arr_req      <= 1'b0;
         arr_wen_data <= '0;
         arr_wen_tag  <= '0;
         cpu_done     <= 1'b0;
         case (state_q)
            IDLE: if (cpu_req) begin
               addr_q      <= cpu_addr;
               wen_q       <= cpu_wen;
               wdata_q     <= cpu_wdata;
               arr_req     <= 1'b1;
               arr_address <= cpu_addr;
               cpu_ready   <= 1'b0;
               look_wait_q <= 1'b0;
               state_q     <= LOOKUP;
            end
            LOOKUP: if (!look_wait_q) begin
               look_wait_q <= 1'b1;
            end else begin
               way_q <= tgt_way;
               if (hit_any) begin
                  lru_q[set_q] <= ~tgt_way;
                  if (!wen_q) begin
                     cpu_rdata <= hit_data;
                     cpu_done  <= 1'b1;
                     state_q   <= DONE;
                  end else begin
                     state_q   <= FILL;
                  end
               end else if (vict_dirty) begin
                  mem_req   <= 1'b1;
                  mem_wen   <= 1'b1;
                  mem_addr  <= {vict_tag, set_q, {OFF_BITS{1'b0}}};
                  mem_wdata <= vict_data;
                  state_q   <= WRITEBACK;
               end else if (wen_q) begin
                  state_q   <= FILL;
               end else begin
                  mem_req   <= 1'b1;
                  mem_wen   <= 1'b0;
                  mem_addr  <= line_addr;
                  state_q   <= REFILL;
               end
            end
            WRITEBACK: if (mem_ack) begin
               mem_req <= 1'b0;
               mem_wen <= 1'b0;
               state_q <= wen_q ? FILL : REFILL;
            end
            // After a writeback mem_req is low for one cycle before the refill request.
            REFILL: if (!mem_req) begin
               mem_req  <= 1'b1;
               mem_wen  <= 1'b0;
               mem_addr <= line_addr;
            end else if (mem_ack) begin
               mem_req   <= 1'b0;
               cpu_rdata <= mem_rdata;
               state_q   <= FILL;
            end
            FILL: begin
               lru_q[set_q] <= ~way_q;
               cpu_done     <= 1'b1;
               state_q      <= DONE;
            end
            DONE: begin
               cpu_ready <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         if (enter_fill) begin
            arr_req            <= 1'b1;
            arr_wen_data       <= tgt_mask;
            arr_wen_tag        <= tgt_mask;
            arr_valid_dirty_in <= {WAYS{wen_q, 1'b1}};
            arr_tag_in         <= tag_q;
            arr_data_in        <= wen_q ? wdata_q : mem_rdata;
         end
`ifdef CACHE_PERF_CNT_EN
         if (lookup_eval) begin
            if (hit_any && hit_cnt_q != 32'hFFFF_FFFF)
               hit_cnt_q <= hit_cnt_q + 32'd1;
            if (!hit_any && miss_cnt_q != 32'hFFFF_FFFF)
               miss_cnt_q <= miss_cnt_q + 32'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a registered tag/data array model and a
// backing-memory responder fed from an expected-transaction scoreboard.
module tb_cache_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_wen;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_ready, cpu_done;
   logic [31:0] cpu_rdata;
   logic        arr_req;
   logic [31:0] arr_address, arr_data_in;
   logic [1:0]  arr_wen_data, arr_wen_tag;
   logic [3:0]  arr_valid_dirty_in;
   logic [19:0] arr_tag_in;
   logic [63:0] arr_data_out;
   logic [3:0]  arr_valid_dirty_out;
   logic [39:0] arr_tag_out;
   logic        mem_req, mem_wen, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_PERF_CNT_EN
   logic [31:0] hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   cache_controller dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .arr_req(arr_req), .arr_address(arr_address), .arr_data_in(arr_data_in),
      .arr_wen_data(arr_wen_data), .arr_wen_tag(arr_wen_tag),
      .arr_valid_dirty_in(arr_valid_dirty_in), .arr_tag_in(arr_tag_in),
      .arr_data_out(arr_data_out), .arr_valid_dirty_out(arr_valid_dirty_out),
      .arr_tag_out(arr_tag_out),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_PERF_CNT_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] data;
   } mem_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          mem_cnt = 0;
   int          arr_wr_cnt = 0;
   int          done_cnt = 0;
   logic        mem_hold = 1'b0;
   mem_t        exp_mem_q[$];
   logic [31:0] exp_rd_q[$];

   logic [31:0] data_m [2][1024];
   logic [19:0] tag_m  [2][1024];
   logic [1:0]  vd_m   [2][1024];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Array: registered read outputs one cycle after arr_req, write on arr_req with enables.
   initial begin
      for (int w = 0; w < 2; w++)
         for (int s = 0; s < 1024; s++) begin
            data_m[w][s] = '0; tag_m[w][s] = '0; vd_m[w][s] = '0;
         end
      arr_data_out = '0; arr_tag_out = '0; arr_valid_dirty_out = '0;
   end

   always @(posedge clk) begin
      if (arr_req) begin
         arr_data_out        <= {data_m[1][arr_address[11:2]], data_m[0][arr_address[11:2]]};
         arr_tag_out         <= {tag_m[1][arr_address[11:2]], tag_m[0][arr_address[11:2]]};
         arr_valid_dirty_out <= {vd_m[1][arr_address[11:2]], vd_m[0][arr_address[11:2]]};
         for (int w = 0; w < 2; w++) begin
            if (arr_wen_data[w]) begin
               data_m[w][arr_address[11:2]] <= arr_data_in;
               arr_wr_cnt++;
            end
            if (arr_wen_tag[w]) begin
               tag_m[w][arr_address[11:2]] <= arr_tag_in;
               vd_m[w][arr_address[11:2]]  <= arr_valid_dirty_in[2*w +: 2];
               arr_wr_cnt++;
            end
         end
      end
   end

   always @(posedge clk) if (cpu_done) done_cnt++;

   // Backing memory: acks the third cycle of a request, checks it against the scoreboard.
   initial begin
      mem_t e;
      int   wcnt;
      wcnt = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0;
            mem_rdata = '0;
         end else if (mem_req && !mem_hold && !rst) begin
            wcnt++;
            if (wcnt == 3) begin
               wcnt = 0;
               mem_cnt++;
               if (exp_mem_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL mem_unexpected: observed wen=%0d addr=%h, expected no request",
                           mem_wen, mem_addr);
               end else begin
                  e = exp_mem_q.pop_front();
                  check("mem_wen", 64'(mem_wen), 64'(e.wen));
                  check("mem_addr", 64'(mem_addr), 64'(e.addr));
                  if (e.wen) check("mem_wdata", 64'(mem_wdata), 64'(e.data));
                  else mem_rdata = e.data;
               end
               mem_ack = 1'b1;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input int exp_lat, input string tag);
      int cyc;
      int guard;
      guard = 0;
      while (!cpu_ready && guard < 50) begin @(negedge clk); guard++; end
      cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
      if (!wen) exp_rd_q.push_back(exp_rd);
      @(negedge clk);
      cpu_req = 1'b0;
      cyc = 1;
      while (!cpu_done && cyc < 200) begin @(negedge clk); cyc++; end
      if (!cpu_done) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: observed no cpu_done in %0d cycles, expected completion", tag, cyc);
         exp_rd_q.delete();
      end else begin
         if (!wen) check({tag, "_rdata"}, 64'(cpu_rdata), 64'(exp_rd_q.pop_front()));
         if (exp_lat != 0) check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      end
   endtask

   initial begin
      int m0, w0, d0, guard;
      rst = 1'b1; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready",  64'(cpu_ready), 64'd1);
      check("rst_done",   64'(cpu_done), 64'd0);
      check("rst_memreq", 64'(mem_req), 64'd0);
      check("rst_memwen", 64'(mem_wen), 64'd0);
      check("rst_arrreq", 64'(arr_req), 64'd0);
      check("rst_wen",    64'({arr_wen_data, arr_wen_tag}), 64'd0);
      check("rst_rdata",  64'(cpu_rdata), 64'd0);
      check("rst_memadr", 64'(mem_addr), 64'd0);
      check("rst_memwd",  64'(mem_wdata), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // cold read miss, refill into way0
      exp_mem_q.push_back('{1'b0, 32'h0000_1004, 32'hDEAD_BEEF});
      do_req(1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, "cold_rd");
      @(negedge clk);
      check("cold_vd0",  64'(vd_m[0][1]), 64'b01);
      check("cold_tag0", 64'(tag_m[0][1]), 64'd1);

      // repeat read hits, no memory traffic
      m0 = mem_cnt;
      do_req(1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 3, "hit_rd");
      check("hit_nomem", 64'(mem_cnt), 64'(m0));
`ifdef CACHE_PERF_CNT_EN
      check("hit_count",  64'(hit_count), 64'd1);
      check("miss_count", 64'(miss_count), 64'd1);
`endif

      // write miss allocates way1 without refill
      do_req(1'b1, 32'h0000_2004, 32'h1234_5678, 32'h0, 0, "wr_miss");
      @(negedge clk);
      check("wr_nomem",  64'(mem_cnt), 64'(m0));
      check("wr_vd1",    64'(vd_m[1][1]), 64'b11);
      check("wr_data1",  64'(data_m[1][1]), 64'h1234_5678);
      check("wr_vd0",    64'(vd_m[0][1]), 64'b01);

      // read miss: lru victim way0 is clean, refill only
      exp_mem_q.push_back('{1'b0, 32'h0000_3004, 32'hCAFE_F00D});
      do_req(1'b0, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, 0, "rd_clean");
      @(negedge clk);
      check("clean_tag0",  64'(tag_m[0][1]), 64'd3);
      check("clean_data1", 64'(data_m[1][1]), 64'h1234_5678);

      // read miss: victim way1 dirty, writeback then refill
      exp_mem_q.push_back('{1'b1, 32'h0000_2004, 32'h1234_5678});
      exp_mem_q.push_back('{1'b0, 32'h0000_4004, 32'h0BAD_C0DE});
      do_req(1'b0, 32'h0000_4004, 32'h0, 32'h0BAD_C0DE, 0, "rd_dirty");
      @(negedge clk);
      check("dirty_vd1",  64'(vd_m[1][1]), 64'b01);
      check("dirty_tag1", 64'(tag_m[1][1]), 64'd4);
      check("dirty_q",    64'(exp_mem_q.size()), 64'd0);

      // write hit then read hit on way1
      m0 = mem_cnt;
      do_req(1'b1, 32'h0000_4004, 32'hA5A5_A5A5, 32'h0, 0, "wr_hit");
      @(negedge clk);
      check("wrhit_vd1",   64'(vd_m[1][1]), 64'b11);
      check("wrhit_data1", 64'(data_m[1][1]), 64'hA5A5_A5A5);
      do_req(1'b0, 32'h0000_4004, 32'h0, 32'hA5A5_A5A5, 3, "rdhit_w1");
      check("wrhit_nomem", 64'(mem_cnt), 64'(m0));

      // reset while a refill is outstanding
      mem_hold = 1'b1;
      guard = 0;
      while (!cpu_ready && guard < 50) begin @(negedge clk); guard++; end
      cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_5004;
      @(negedge clk);
      cpu_req = 1'b0;
      guard = 0;
      while (!mem_req && guard < 50) begin @(negedge clk); guard++; end
      check("rstrefill_req", 64'(mem_req), 64'd1);
      check("rstrefill_adr", 64'(mem_addr), 64'h0000_5004);
      w0 = arr_wr_cnt;
      rst = 1'b1;
      @(negedge clk);
      check("rstrefill_memreq", 64'(mem_req), 64'd0);
      check("rstrefill_ready",  64'(cpu_ready), 64'd1);
      rst = 1'b0;
      mem_hold = 1'b0;
      repeat (5) @(negedge clk);
      check("rstrefill_nowr", 64'(arr_wr_cnt), 64'(w0));
      check("rstrefill_tag0", 64'(tag_m[0][1]), 64'd3);
      check("rstrefill_idle", 64'(mem_req), 64'd0);

      // cpu_req pulsed during LOOKUP is ignored
      m0 = mem_cnt;
      d0 = done_cnt;
      cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_3004;
      @(negedge clk);
      cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h0000_4004; cpu_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      cpu_req = 1'b0;
      guard = 0;
      while (!cpu_done && guard < 50) begin @(negedge clk); guard++; end
      check("pulse_rdata", 64'(cpu_rdata), 64'hCAFE_F00D);
      repeat (15) @(negedge clk);
      check("pulse_ndone", 64'(done_cnt - d0), 64'd1);
      check("pulse_data1", 64'(data_m[1][1]), 64'hA5A5_A5A5);
      check("pulse_nomem", 64'(mem_cnt), 64'(m0));
      check("final_memq",  64'(exp_mem_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed simulation still running, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameters SHALL be:
- ADDRESS_WIDTH, default 32, byte address width.
- SETS, default 1024, sets per way; power of two.
- WAYS, default 2, associativity; fixed at 2 in this block.
- CACHE_LINE_SIZE, default 32, line width and CPU data width in bits.
- TAG_WIDTH, default ADDRESS_WIDTH-(log2(SETS)+log2(CACHE_LINE_SIZE/8)), tag width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: clock, rising edge.
- rst in 1: reset, synchronous, active-high.
- cpu_req in 1: CPU request valid.
- cpu_wen in 1: 1 = write, 0 = read.
- cpu_addr in ADDRESS_WIDTH: request address.
- cpu_wdata in CACHE_LINE_SIZE: write data.
- cpu_ready out 1: controller can accept a request.
- cpu_done out 1: one-cycle completion pulse.
- cpu_rdata out CACHE_LINE_SIZE: read data, valid while cpu_done=1.
- arr_req out 1: array access strobe.
- arr_address out ADDRESS_WIDTH: array address; the array uses the set bits only.
- arr_data_in out CACHE_LINE_SIZE: array write data.
- arr_wen_data out WAYS: per-way data write enable.
- arr_wen_tag out WAYS: per-way tag and valid/dirty write enable.
- arr_valid_dirty_in out 2 x WAYS: per-way {dirty, valid}.
- arr_tag_in out TAG_WIDTH: tag to write.
- arr_data_out in CACHE_LINE_SIZE x WAYS: per-way read data, one cycle after arr_req.
- arr_valid_dirty_out in 2 x WAYS: per-way {dirty, valid}, one cycle after arr_req.
- arr_tag_out in TAG_WIDTH x WAYS: per-way tag, one cycle after arr_req.
- mem_req out 1: backing-memory request, held until mem_ack.
- mem_wen out 1: 1 = writeback, 0 = refill.
- mem_addr out ADDRESS_WIDTH: line-aligned address, offset bits 0.
- mem_wdata out CACHE_LINE_SIZE: writeback data.
- mem_ack in 1: one-cycle completion from backing memory.
- mem_rdata in CACHE_LINE_SIZE: refill data, valid while mem_ack=1.

Function
REQ-003 The controller SHALL implement the states IDLE, LOOKUP, WRITEBACK, REFILL, FILL and DONE.
REQ-004 cpu_ready SHALL be 1 only in IDLE; cpu_req is accepted on a cycle with cpu_req=1 and cpu_ready=1, and cpu_req in any other state SHALL be ignored.
REQ-005 On accept, the controller SHALL latch cpu_addr, cpu_wen and cpu_wdata, drive arr_req=1 with all arr_wen_* bits 0, and go to LOOKUP.
REQ-006 LOOKUP SHALL compute a per-way hit as valid & (tag_out == latched tag), and SHALL latch the victim way's data, tag and valid/dirty.
REQ-007 Read hit on way w: cpu_rdata <= arr_data_out[w], then go to DONE; this gives 3 cycles from accept to cpu_done.
REQ-008 Write hit on way w: drive arr_req=1, arr_wen_data[w]=1, arr_wen_tag[w]=1, valid_dirty {1,1}, data_in=cpu_wdata; then go to DONE.
REQ-009 On a miss, the victim SHALL be the lowest-numbered invalid way; if both ways are valid, the victim SHALL be lru[set].
REQ-010 Victim valid and dirty: go to WRITEBACK.
- mem_req=1, mem_wen=1.
- mem_addr = {victim tag, set, 0}, mem_wdata = victim data.
- Signals held stable until mem_ack.
REQ-011 After WRITEBACK, or on a miss with a clean or invalid victim: a read miss SHALL go to REFILL and a write miss SHALL go to FILL with no refill, because a write covers the full line.
REQ-012 REFILL: mem_req=1, mem_wen=0, mem_addr = {tag, set, 0}; on mem_ack, capture mem_rdata and go to FILL.
REQ-013 FILL SHALL write the victim way for one cycle, then go to DONE.
- Data: cpu_wdata on a write, captured refill data on a read.
- Tag: latched tag.
- valid_dirty: {cpu_wen, 1}.
- On a read, cpu_rdata = refill data.
REQ-014 DONE: cpu_done=1 for exactly one cycle, then go to IDLE.
REQ-015 The controller SHALL hold an internal lru array of SETS bits; on every hit or fill to way w, lru[set] <= ~w.
REQ-016 mem_req SHALL deassert in the cycle after mem_ack; mem_ack received outside WRITEBACK or REFILL SHALL be ignored.
REQ-017 arr_req SHALL be 0 in WRITEBACK, REFILL and DONE.

Reset
REQ-018 On rst, the following SHALL take effect on the next cycle:
- State = IDLE.
- cpu_ready=1.
- cpu_done, mem_req, mem_wen, arr_req and all arr_wen_* = 0.
- cpu_rdata, mem_addr and mem_wdata = 0.
- All lru bits = 0.
REQ-019 Reset during any state, including an outstanding mem_req, SHALL abandon the transaction without writing the array; the backing memory SHALL tolerate mem_req dropping before mem_ack.

Configuration
REQ-020 With CACHE_PERF_CNT_EN defined, the controller SHALL add the outputs hit_count (32) and miss_count (32).
- Counters reset to 0.
- Incremented in LOOKUP on a hit or a miss respectively.
- Saturate at 0xFFFFFFFF.
REQ-021 Without CACHE_PERF_CNT_EN, the ports and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-022 The bench SHALL cover these directed scenarios (address fields with defaults: set = addr[11:2], tag = addr[31:12]):
- Cold read of 0x00001004 after reset -> mem_req read at 0x00001004; mem_ack with 0xDEADBEEF -> cpu_done, rdata 0xDEADBEEF; way0 {dirty,valid} = 01.
- Repeat read of 0x00001004 -> no mem_req; cpu_done 3 cycles after accept; rdata 0xDEADBEEF; hit_count=1.
- Write 0x12345678 to 0x00002004 -> way1 filled, no mem traffic, dirty=1.
- Read 0x00003004 -> victim way0 (clean), refill only. Then read 0x00004004 -> victim way1 is dirty: writeback addr 0x00002004 data 0x12345678, then refill.
- rst asserted in REFILL with mem_req=1 -> next cycle mem_req=0, cpu_ready=1; the array is not written.
- cpu_req pulsed while in LOOKUP -> ignored; only the first request completes.
